// File: rtl/demux1_8_regbank.sv
// rtl/demux1_8_regbank.sv - 1:8 write demux into holding registers with auto-increment burst
module demux1_8_regbank #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] In,
    input  logic [2:0]       Op,
    input  logic             WE,
    input  logic             Burst_Start,
    input  logic [2:0]       Burst_Len,
    input  logic             In_Valid,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] E,
    output logic [WIDTH-1:0] F,
    output logic [WIDTH-1:0] G,
    output logic [WIDTH-1:0] H,
    output logic [7:0]       Valid,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state, state_n;
    logic [2:0]       ptr, ptr_n;
    logic [2:0]       rem, rem_n;
    logic             done_n;
    logic             wr_en;
    logic [2:0]       wr_idx;
    logic [WIDTH-1:0] slots [8];

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
            ptr   <= 3'd0;
            rem   <= 3'd0;
            Done  <= 1'b0;
            Valid <= 8'h00;
            for (int i = 0; i < 8; i++) slots[i] <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            rem   <= rem_n;
            Done  <= done_n;
            if (wr_en) begin
                slots[wr_idx] <= In;
                Valid[wr_idx] <= 1'b1;
            end
        end
    end

    // Burst_Start outranks WE; a zero-length burst completes in IDLE like a single write.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        rem_n   = rem;
        done_n  = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = ptr;
        case (state)
            IDLE: begin
                if (Burst_Start) begin
                    wr_en  = 1'b1;
                    wr_idx = Op;
                    ptr_n  = Op + 3'd1;
                    rem_n  = Burst_Len;
                    if (Burst_Len == 3'd0) done_n = 1'b1;
                    else                   state_n = BURST;
                end else if (WE) begin
                    wr_en  = 1'b1;
                    wr_idx = Op;
                    done_n = 1'b1;
                end
            end
            BURST: begin
                if (In_Valid) begin
                    wr_en  = 1'b1;
                    wr_idx = ptr;
                    ptr_n  = ptr + 3'd1;
                    rem_n  = rem - 3'd1;
                    if (rem == 3'd1) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign Busy = (state == BURST);
    assign A = slots[0];
    assign B = slots[1];
    assign C = slots[2];
    assign D = slots[3];
    assign E = slots[4];
    assign F = slots[5];
    assign G = slots[6];
    assign H = slots[7];

endmodule

// File: tb/tb_demux1_8_regbank.sv
// tb/tb_demux1_8_regbank.sv - directed self-checking bench for demux1_8_regbank
module tb_demux1_8_regbank;

    logic        CLK = 1'b0;
    logic        Reset, WE, Burst_Start, In_Valid;
    logic [15:0] In;
    logic [2:0]  Op, Burst_Len;
    logic [15:0] A, B, C, D, E, F, G, H;
    logic [7:0]  Valid;
    logic        Busy, Done;

    int vectors = 0;
    int miscompares = 0;

    demux1_8_regbank #(.WIDTH(16)) dut (
        .CLK(CLK), .Reset(Reset), .In(In), .Op(Op), .WE(WE),
        .Burst_Start(Burst_Start), .Burst_Len(Burst_Len), .In_Valid(In_Valid),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H),
        .Valid(Valid), .Busy(Busy), .Done(Done)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] e [8]);
        check({tag, "_A"}, A, e[0]);
        check({tag, "_B"}, B, e[1]);
        check({tag, "_C"}, C, e[2]);
        check({tag, "_D"}, D, e[3]);
        check({tag, "_E"}, E, e[4]);
        check({tag, "_F"}, F, e[5]);
        check({tag, "_G"}, G, e[6]);
        check({tag, "_H"}, H, e[7]);
    endtask

    logic [15:0] exp_s [8];

    initial begin
        Reset = 1'b1; WE = 1'b0; Burst_Start = 1'b0; In_Valid = 1'b0;
        In = 16'h0; Op = 3'd0; Burst_Len = 3'd0;
        tick;
        Reset = 1'b0;

        // 1: preload two slots, then reset clears everything
        WE = 1'b1; Op = 3'd1; In = 16'h1234; tick;
        Op = 3'd7; In = 16'h5678; tick;
        WE = 1'b0;
        check("preload_B", B, 16'h1234);
        check("preload_valid", {8'h0, Valid}, 16'h0082);
        Reset = 1'b1; tick; Reset = 1'b0;
        for (int i = 0; i < 8; i++) exp_s[i] = 16'h0;
        check_all("rst", exp_s);
        check("rst_valid", {8'h0, Valid}, 16'h0000);
        check("rst_busy", {15'h0, Busy}, 16'h0);
        check("rst_done", {15'h0, Done}, 16'h0);

        // 2: single write to slot 5
        WE = 1'b1; Op = 3'd5; In = 16'hBEEF; tick;
        WE = 1'b0;
        exp_s[5] = 16'hBEEF;
        check_all("single", exp_s);
        check("single_valid", {8'h0, Valid}, 16'h0020);
        check("single_done", {15'h0, Done}, 16'h1);
        tick;
        check("single_done_drop", {15'h0, Done}, 16'h0);

        // 3: wrapping burst 6,7,0,1
        Burst_Start = 1'b1; Op = 3'd6; Burst_Len = 3'd3; In = 16'd1; tick;
        Burst_Start = 1'b0;
        check("wrap_G", G, 16'd1);
        check("wrap_busy1", {15'h0, Busy}, 16'h1);
        check("wrap_done1", {15'h0, Done}, 16'h0);
        In_Valid = 1'b1; In = 16'd2; tick;
        check("wrap_H", H, 16'd2);
        check("wrap_busy2", {15'h0, Busy}, 16'h1);
        In = 16'd3; tick;
        check("wrap_A", A, 16'd3);
        check("wrap_busy3", {15'h0, Busy}, 16'h1);
        check("wrap_done3", {15'h0, Done}, 16'h0);
        In = 16'd4; tick;
        In_Valid = 1'b0;
        exp_s[6] = 16'd1; exp_s[7] = 16'd2; exp_s[0] = 16'd3; exp_s[1] = 16'd4;
        check_all("wrap", exp_s);
        check("wrap_busy4", {15'h0, Busy}, 16'h0);
        check("wrap_done4", {15'h0, Done}, 16'h1);
        check("wrap_valid", {8'h0, Valid}, 16'h00E3);
        tick;
        check("wrap_done5", {15'h0, Done}, 16'h0);

        // 4: same burst with a two-cycle stall while WE/Op=0/FFFF are driven
        Reset = 1'b1; tick; Reset = 1'b0;
        Burst_Start = 1'b1; Op = 3'd6; Burst_Len = 3'd3; In = 16'd1; tick;
        Burst_Start = 1'b0; WE = 1'b1; Op = 3'd0;
        In_Valid = 1'b1; In = 16'd2; tick;
        In_Valid = 1'b0; In = 16'hFFFF; tick;
        check("stall1_A", A, 16'h0);
        check("stall1_busy", {15'h0, Busy}, 16'h1);
        check("stall1_done", {15'h0, Done}, 16'h0);
        tick;
        check("stall2_A", A, 16'h0);
        check("stall2_H", H, 16'd2);
        check("stall2_busy", {15'h0, Busy}, 16'h1);
        In_Valid = 1'b1; In = 16'd3; tick;
        check("stall_A", A, 16'd3);
        check("stall_done_early", {15'h0, Done}, 16'h0);
        In = 16'd4; tick;
        WE = 1'b0; In_Valid = 1'b0;
        for (int i = 0; i < 8; i++) exp_s[i] = 16'h0;
        exp_s[6] = 16'd1; exp_s[7] = 16'd2; exp_s[0] = 16'd3; exp_s[1] = 16'd4;
        check_all("stall", exp_s);
        check("stall_valid", {8'h0, Valid}, 16'h00C3);
        check("stall_done", {15'h0, Done}, 16'h1);
        check("stall_busy", {15'h0, Busy}, 16'h0);

        // 5: full-depth burst 0..7 with data 10..17, then back-to-back WE in the Done cycle
        Burst_Start = 1'b1; Op = 3'd0; Burst_Len = 3'd7; In = 16'h0010; tick;
        Burst_Start = 1'b0; In_Valid = 1'b1;
        for (int i = 1; i < 8; i++) begin
            In = 16'h0010 + 16'(i);
            tick;
        end
        In_Valid = 1'b0;
        for (int i = 0; i < 8; i++) exp_s[i] = 16'h0010 + 16'(i);
        check_all("full", exp_s);
        check("full_valid", {8'h0, Valid}, 16'h00FF);
        check("full_done", {15'h0, Done}, 16'h1);
        WE = 1'b1; Op = 3'd0; In = 16'h00AA; tick;
        WE = 1'b0;
        check("b2b_A", A, 16'h00AA);
        check("b2b_B", B, 16'h0011);
        check("b2b_done", {15'h0, Done}, 16'h1);

        // 6: reset after two words of a five-word burst, then a one-word burst
        Burst_Start = 1'b1; Op = 3'd0; Burst_Len = 3'd4; In = 16'h0020; tick;
        Burst_Start = 1'b0; In_Valid = 1'b1; In = 16'h0021; tick;
        Reset = 1'b1; In = 16'h0022; tick;
        Reset = 1'b0; In_Valid = 1'b0;
        for (int i = 0; i < 8; i++) exp_s[i] = 16'h0;
        check_all("midrst", exp_s);
        check("midrst_valid", {8'h0, Valid}, 16'h0000);
        check("midrst_busy", {15'h0, Busy}, 16'h0);
        check("midrst_done", {15'h0, Done}, 16'h0);
        tick;
        check("midrst_done2", {15'h0, Done}, 16'h0);
        Burst_Start = 1'b1; Op = 3'd3; Burst_Len = 3'd0; In = 16'd7; tick;
        Burst_Start = 1'b0;
        check("len0_D", D, 16'd7);
        check("len0_done", {15'h0, Done}, 16'h1);
        check("len0_busy", {15'h0, Busy}, 16'h0);
        check("len0_valid", {8'h0, Valid}, 16'h0008);
        tick;
        check("len0_done_drop", {15'h0, Done}, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
